// File: rtl/wb_master_pkg.sv
// Shared constants and types for the Wishbone burst master.
// Cycle-type / burst-type codes and the bus-cycle state enum.
package wb_master_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;
  localparam logic [1:0] BTE_LINEAR  = 2'b00;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

endpackage

// File: rtl/wb_wr_stage.sv
// Single-entry write holding register between wr_* port and bus.
// Ports: clk/rst_n, load_i+data_i in, consume_i, flush_i; valid/data out.
module wb_wr_stage
  import wb_master_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_i,
  input  logic [DW-1:0] data_i,
  input  logic          consume_i,
  input  logic          flush_i,
  output logic          valid_o,
  output logic          valid_d_o,
  output logic [DW-1:0] data_o
);

  logic          valid_q, valid_d;
  logic [DW-1:0] data_q, data_d;

  // A load in the same cycle as a consume refills the slot.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (consume_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o   = valid_q;
  assign valid_d_o = valid_d;
  assign data_o    = data_q;

endmodule

// File: rtl/wb_burst_master.sv
// Wishbone B3 incrementing-burst master: one command -> one bus cycle.
// Ports: cmd_* command, wr_* write stream, rd_* read stream, done/err, wb_*.
module wb_burst_master
  import wb_master_pkg::*;
#(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int SW        = DW / 8,
  parameter int MAX_BURST = 8,
  parameter int LW        = $clog2(MAX_BURST) + 1
) (
  input  logic          wb_clk_i,
  input  logic          RESETN,
  input  logic          cmd_valid_i,
  output logic          cmd_ready_o,
  input  logic          cmd_we_i,
  input  logic [AW-1:0] cmd_addr_i,
  input  logic [LW-1:0] cmd_len_i,
  input  logic [SW-1:0] cmd_sel_i,
  input  logic          wr_valid_i,
  input  logic [DW-1:0] wr_data_i,
  output logic          wr_ready_o,
  output logic          rd_valid_o,
  output logic [DW-1:0] rd_data_o,
  output logic          done_o,
  output logic          err_o,
  output logic          wb_cyc_o,
  output logic          wb_stb_o,
  output logic          wb_we_o,
  output logic [AW-1:0] wb_addr_o,
  output logic [DW-1:0] wb_dat_o,
  output logic [SW-1:0] wb_sel_o,
  output logic [2:0]    wb_cti_o,
  output logic [1:0]    wb_bte_o,
  input  logic          wb_ack_i,
  input  logic          wb_err_i,
  input  logic [DW-1:0] wb_dat_i
);

  state_e        state_q, state_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [SW-1:0] sel_q, sel_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] rem_q, rem_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic          stb_q, stb_d;
  logic [2:0]    cti_q, cti_d;
  logic          rd_valid_q, rd_valid_d;
  logic [DW-1:0] rd_data_q, rd_data_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic          in_burst;
  logic          beat;
  logic          err_hit;
  logic          consume;
  logic          load;
  logic          stg_valid;
  logic          stg_valid_d;
  logic [LW-1:0] len_c;

  // Error outranks a simultaneous ack.
  assign in_burst = (state_q == BURST);
  assign err_hit  = stb_q & wb_err_i;
  assign beat     = stb_q & wb_ack_i & ~wb_err_i;
  assign consume  = beat & we_q;

  // cnt_q counts beats taken this command, staged or already sent.
  assign wr_ready_o = in_burst & we_q
                    & (~stg_valid | consume)
                    & (cnt_q < len_q);
  assign load = wr_valid_i & wr_ready_o;

  always_comb begin
    len_c = cmd_len_i;
    if (cmd_len_i == '0) begin
      len_c = LW'(1);
    end else if (cmd_len_i > LW'(MAX_BURST)) begin
      len_c = LW'(MAX_BURST);
    end
  end

  wb_wr_stage #(
    .DW(DW)
  ) u_wr_stage (
    .clk       (wb_clk_i),
    .rst_n     (RESETN),
    .load_i    (load),
    .data_i    (wr_data_i),
    .consume_i (consume),
    .flush_i   (err_hit),
    .valid_o   (stg_valid),
    .valid_d_o (stg_valid_d),
    .data_o    (wb_dat_o)
  );

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    addr_d     = addr_q;
    sel_d      = sel_q;
    len_d      = len_q;
    rem_d      = rem_q;
    cnt_d      = cnt_q;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    if (load) begin
      cnt_d = cnt_q + LW'(1);
    end
    case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          state_d = BURST;
          we_d    = cmd_we_i;
          addr_d  = cmd_addr_i;
          sel_d   = cmd_sel_i;
          len_d   = len_c;
          rem_d   = len_c;
          cnt_d   = '0;
        end
      end
      BURST: begin
        if (err_hit) begin
          state_d = IDLE;
          rem_d   = '0;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else if (beat) begin
          rem_d  = rem_q - LW'(1);
          addr_d = addr_q + AW'(SW);
          if (!we_q) begin
            rd_valid_d = 1'b1;
            rd_data_d  = wb_dat_i;
          end
          if (rem_q == LW'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    cti_d = CTI_CLASSIC;
    if (state_d == BURST) begin
      cti_d = (rem_d > LW'(1)) ? CTI_INCR : CTI_EOB;
    end
  end

  // Writes strobe only while a beat is staged: master wait state.
  assign stb_d = (state_d == BURST)
               & (we_d ? stg_valid_d : 1'b1);

  always_ff @(posedge wb_clk_i) begin
    if (!RESETN) begin
      state_q    <= IDLE;
      we_q       <= 1'b0;
      addr_q     <= '0;
      sel_q      <= '0;
      len_q      <= '0;
      rem_q      <= '0;
      cnt_q      <= '0;
      stb_q      <= 1'b0;
      cti_q      <= CTI_CLASSIC;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      sel_q      <= sel_d;
      len_q      <= len_d;
      rem_q      <= rem_d;
      cnt_q      <= cnt_d;
      stb_q      <= stb_d;
      cti_q      <= cti_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign cmd_ready_o = (state_q == IDLE);
  assign wb_cyc_o    = in_burst;
  assign wb_stb_o    = stb_q;
  assign wb_we_o     = we_q;
  assign wb_addr_o   = addr_q;
  assign wb_sel_o    = sel_q;
  assign wb_cti_o    = cti_q;
  assign wb_bte_o    = BTE_LINEAR;
  assign rd_valid_o  = rd_valid_q;
  assign rd_data_o   = rd_data_q;
  assign done_o      = done_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_wb_burst_master.sv
// Scoreboard bench for wb_burst_master with a randomised slave.
// Model queues: bus beats, read data, done events.
module tb_wb_burst_master;

  localparam int SW = 4;

  logic        clk = 1'b0;
  logic        RESETN = 1'b0;
  logic        cmd_valid_i, cmd_ready_o, cmd_we_i;
  logic [31:0] cmd_addr_i;
  logic [3:0]  cmd_len_i;
  logic [3:0]  cmd_sel_i;
  logic        wr_valid_i, wr_ready_o;
  logic [31:0] wr_data_i;
  logic        rd_valid_o;
  logic [31:0] rd_data_o;
  logic        done_o, err_o;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [31:0] wb_addr_o, wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic [2:0]  wb_cti_o;
  logic [1:0]  wb_bte_o;
  logic        wb_ack_i, wb_err_i;
  logic [31:0] wb_dat_i;

  always #5 clk = ~clk;

  wb_burst_master dut (
    .wb_clk_i    (clk),
    .RESETN      (RESETN),
    .cmd_valid_i (cmd_valid_i),
    .cmd_ready_o (cmd_ready_o),
    .cmd_we_i    (cmd_we_i),
    .cmd_addr_i  (cmd_addr_i),
    .cmd_len_i   (cmd_len_i),
    .cmd_sel_i   (cmd_sel_i),
    .wr_valid_i  (wr_valid_i),
    .wr_data_i   (wr_data_i),
    .wr_ready_o  (wr_ready_o),
    .rd_valid_o  (rd_valid_o),
    .rd_data_o   (rd_data_o),
    .done_o      (done_o),
    .err_o       (err_o),
    .wb_cyc_o    (wb_cyc_o),
    .wb_stb_o    (wb_stb_o),
    .wb_we_o     (wb_we_o),
    .wb_addr_o   (wb_addr_o),
    .wb_dat_o    (wb_dat_o),
    .wb_sel_o    (wb_sel_o),
    .wb_cti_o    (wb_cti_o),
    .wb_bte_o    (wb_bte_o),
    .wb_ack_i    (wb_ack_i),
    .wb_err_i    (wb_err_i),
    .wb_dat_i    (wb_dat_i)
  );

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  cti;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] dat;
  } beat_t;

  typedef struct {
    logic err;
    logic rd_end;
    int   cyc_len;
  } done_t;

  beat_t       exp_beat_q[$];
  logic [31:0] exp_rd_q[$];
  done_t       exp_done_q[$];

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  int          ack_pct = 100;
  int          err_idx = -1;
  int          slave_idx = 0;
  logic [31:0] salt = 32'h0;

  int          wr_pct = 100;
  logic [31:0] wr_q[$];
  bit          wr_hold = 1'b0;
  int          loaded = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic finish_sim();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  endtask

  function automatic logic [31:0] slave_data(logic [31:0] a,
                                             logic [31:0] s);
    return {a[15:0], ~a[31:16]} ^ s;
  endfunction

  // Slave: random ack delay, error on a chosen beat index.
  initial begin
    wb_ack_i = 1'b0;
    wb_err_i = 1'b0;
    wb_dat_i = '0;
    forever begin
      @(negedge clk);
      wb_ack_i = 1'b0;
      wb_err_i = 1'b0;
      wb_dat_i = $urandom;
      if (wb_stb_o) begin
        if (slave_idx == err_idx) begin
          wb_err_i = 1'b1;
          wb_ack_i = 1'($urandom_range(1));
          slave_idx++;
        end else if ($urandom_range(99) < ack_pct) begin
          wb_ack_i = 1'b1;
          wb_dat_i = slave_data(wb_addr_o, salt);
          slave_idx++;
        end
      end
    end
  end

  // Write source with random gaps; holds a beat until taken.
  initial begin
    wr_valid_i = 1'b0;
    wr_data_i = '0;
    forever begin
      @(negedge clk);
      #1;
      if (!wr_hold) begin
        if (wr_q.size() > 0 && $urandom_range(99) < wr_pct) begin
          wr_valid_i = 1'b1;
          wr_data_i = wr_q[0];
        end else begin
          wr_valid_i = 1'b0;
        end
      end
      #1;
      if (wr_valid_i && wr_ready_o) begin
        void'(wr_q.pop_front());
        loaded++;
        wr_hold = 1'b0;
      end else begin
        wr_hold = wr_valid_i;
      end
    end
  end

  // Bus beat monitor.
  initial begin
    beat_t b;
    forever begin
      @(negedge clk);
      #3;
      if (RESETN && wb_stb_o && (wb_ack_i || wb_err_i)) begin
        if (exp_beat_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL bus_beat: unexpected beat addr %0h",
                   wb_addr_o);
        end else begin
          b = exp_beat_q.pop_front();
          chk("wb_addr", wb_addr_o, b.addr);
          chk("wb_cti", 32'(wb_cti_o), 32'(b.cti));
          chk("wb_we", 32'(wb_we_o), 32'(b.we));
          chk("wb_sel", 32'(wb_sel_o), 32'(b.sel));
          chk("wb_cyc", 32'(wb_cyc_o), 32'd1);
          chk("wb_bte", 32'(wb_bte_o), 32'd0);
          if (b.we) chk("wb_dat", wb_dat_o, b.dat);
        end
      end
    end
  end

  // Read data monitor.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      #3;
      if (rd_valid_o) begin
        if (exp_rd_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rd_valid: unexpected pulse data %0h",
                   rd_data_o);
        end else begin
          e = exp_rd_q.pop_front();
          chk("rd_data", rd_data_o, e);
        end
      end
    end
  end

  // Done monitor; also measures length of each cyc run.
  initial begin
    int run;
    int last;
    done_t d;
    run = 0;
    last = 0;
    forever begin
      @(negedge clk);
      #3;
      if (wb_cyc_o) begin
        run++;
      end else begin
        if (run > 0) last = run;
        run = 0;
      end
      if (done_o) begin
        done_cnt++;
        if (exp_done_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL done: unexpected done_o err_o=%0b", err_o);
        end else begin
          d = exp_done_q.pop_front();
          chk("done_err", 32'(err_o), 32'(d.err));
          chk("done_cyc", 32'(wb_cyc_o), 32'd0);
          chk("done_cmd_ready", 32'(cmd_ready_o), 32'd1);
          if (d.rd_end) chk("done_rd_valid", 32'(rd_valid_o), 32'd1);
          if (d.cyc_len > 0) chk("cyc_len", last, d.cyc_len);
        end
      end else if (err_o) begin
        checks++;
        errors++;
        $display("FAIL err_o: got 1 expected 0 without done_o");
      end
    end
  end

  task automatic run_cmd(logic we, logic [31:0] addr, logic [3:0] len,
                         logic [3:0] sel, int eidx, int apct, int wpct);
    int L;
    int nb;
    int start;
    logic [31:0] wd[$];
    logic [31:0] s;
    done_t d;
    beat_t b;
    L = (len == 0) ? 1 : ((len > 8) ? 8 : int'(len));
    if (eidx >= L) eidx = -1;
    nb = (eidx < 0) ? L : eidx + 1;
    s = $urandom;
    for (int k = 0; k < L + 1; k++) wd.push_back($urandom);
    for (int k = 0; k < nb; k++) begin
      b.addr = addr + 32'(k * SW);
      b.cti = (k == L - 1) ? 3'b111 : 3'b010;
      b.we = we;
      b.sel = sel;
      b.dat = wd[k];
      exp_beat_q.push_back(b);
      if (!we && k != eidx) exp_rd_q.push_back(slave_data(b.addr, s));
    end
    d.err = (eidx >= 0);
    d.rd_end = !we && eidx < 0;
    d.cyc_len = (!we && eidx < 0 && apct == 100) ? L : 0;
    exp_done_q.push_back(d);
    salt = s;
    ack_pct = apct;
    err_idx = eidx;
    slave_idx = 0;
    wr_pct = wpct;
    loaded = 0;
    if (we) wr_q = wd;
    chk("cmd_ready_idle", 32'(cmd_ready_o), 32'd1);
    cmd_we_i = we;
    cmd_addr_i = addr;
    cmd_len_i = len;
    cmd_sel_i = sel;
    cmd_valid_i = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid_i = 1'b0;
    start = done_cnt;
    for (int c = 0; c < 3000 && done_cnt == start; c++) begin
      @(negedge clk);
      #5;
    end
    if (done_cnt == start) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done_o expected one");
      finish_sim();
    end
    chk("wr_loaded", loaded, we ? nb : 0);
    wr_q.delete();
    wr_hold = 1'b0;
    wr_valid_i = 1'b0;
  endtask

  task automatic reset_mid_burst();
    logic [31:0] a;
    logic [31:0] s;
    beat_t b;
    a = 32'h0000_2000;
    s = $urandom;
    for (int k = 0; k < 3; k++) begin
      b.addr = a + 32'(k * SW);
      b.cti = 3'b010;
      b.we = 1'b0;
      b.sel = 4'hF;
      b.dat = '0;
      exp_beat_q.push_back(b);
      exp_rd_q.push_back(slave_data(b.addr, s));
    end
    salt = s;
    ack_pct = 100;
    err_idx = -1;
    slave_idx = 0;
    cmd_we_i = 1'b0;
    cmd_addr_i = a;
    cmd_len_i = 4'd8;
    cmd_sel_i = 4'hF;
    cmd_valid_i = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid_i = 1'b0;
    for (int c = 0; c < 50 && slave_idx < 3; c++) begin
      @(negedge clk);
      #1;
    end
    @(negedge clk);
    RESETN = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_cyc", 32'(wb_cyc_o), 32'd0);
    chk("rst_stb", 32'(wb_stb_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready_o), 32'd1);
    RESETN = 1'b1;
    repeat (3) @(negedge clk);
    #5;
  endtask

  initial begin
    #500000;
    checks++;
    errors++;
    $display("FAIL watchdog: simulation exceeded time budget");
    finish_sim();
  end

  initial begin
    cmd_valid_i = 1'b0;
    cmd_we_i = 1'b0;
    cmd_addr_i = '0;
    cmd_len_i = '0;
    cmd_sel_i = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_cmd_ready0", 32'(cmd_ready_o), 32'd1);
    chk("rst_cyc0", 32'(wb_cyc_o), 32'd0);
    chk("rst_stb0", 32'(wb_stb_o), 32'd0);
    chk("rst_we0", 32'(wb_we_o), 32'd0);
    chk("rst_cti0", 32'(wb_cti_o), 32'd0);
    chk("rst_bte0", 32'(wb_bte_o), 32'd0);
    chk("rst_addr0", wb_addr_o, 32'd0);
    chk("rst_dat0", wb_dat_o, 32'd0);
    chk("rst_sel0", 32'(wb_sel_o), 32'd0);
    chk("rst_rd_valid0", 32'(rd_valid_o), 32'd0);
    chk("rst_rd_data0", rd_data_o, 32'd0);
    chk("rst_done0", 32'(done_o), 32'd0);
    chk("rst_err0", 32'(err_o), 32'd0);
    chk("rst_wr_ready0", 32'(wr_ready_o), 32'd0);
    RESETN = 1'b1;
    @(negedge clk);
    #5;

    run_cmd(1'b0, 32'h0000_0100, 4'd4, 4'hF, -1, 100, 100);
    run_cmd(1'b1, 32'h0000_0200, 4'd3, 4'h3, -1, 100, 33);
    run_cmd(1'b0, 32'h0000_0300, 4'd1, 4'hF, -1, 100, 100);
    run_cmd(1'b0, 32'h0000_0300, 4'd0, 4'hF, -1, 100, 100);
    run_cmd(1'b0, 32'hFFFF_FFFC, 4'd2, 4'hF, -1, 100, 100);
    run_cmd(1'b0, 32'h0000_0400, 4'd15, 4'h5, -1, 100, 100);
    run_cmd(1'b1, 32'h0000_0500, 4'd4, 4'hF, 2, 100, 100);
    run_cmd(1'b1, 32'h0000_0600, 4'd2, 4'hC, -1, 100, 100);
    run_cmd(1'b0, 32'h0000_0700, 4'd5, 4'hF, 1, 60, 100);
    reset_mid_burst();
    run_cmd(1'b0, 32'h0000_0800, 4'd5, 4'hF, -1, 100, 100);

    for (int n = 0; n < 40; n++) begin
      run_cmd(1'($urandom_range(1)), $urandom, 4'($urandom_range(15)),
              4'($urandom_range(15)),
              ($urandom_range(3) == 0) ? int'($urandom_range(7)) : -1,
              int'($urandom_range(100, 40)),
              int'($urandom_range(100, 30)));
    end

    repeat (5) @(negedge clk);
    chk("beat_q_empty", exp_beat_q.size(), 0);
    chk("rd_q_empty", exp_rd_q.size(), 0);
    chk("done_q_empty", exp_done_q.size(), 0);
    finish_sim();
  end

endmodule
